card_deal_controller: RTL and testbench

Sequencing controller for the `seed_random_2_data_path` card generator. It arbitrates card requests from the player and dealer logic with round-robin fairness, and pulses the datapath's card-request input exactly once per grant. It then waits a configurable datapath latency, captures the card and returns it to the granted requester with a one-cycle valid strobe. It also counts cards dealt per shoe, raises deck-empty, and blocks further grants until a reshuffle.

---
 rtl/card_deal_pkg.sv | 11 +
 rtl/card_rr_arbiter.sv | 31 +++
 rtl/card_deal_controller.sv | 112 +++++++++++
 tb/tb_card_deal_controller.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/card_deal_pkg.sv
// card_deal_pkg: shared FSM encodings, requester IDs and shoe defaults for the card deal controller.
package card_deal_pkg;
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_REQ     = 2'd1;
    localparam state_t ST_WAIT    = 2'd2;
    localparam state_t ST_DELIVER = 2'd3;
    localparam logic PLAYER = 1'b0;
    localparam logic DEALER = 1'b1;
    localparam int DECK_SIZE_DEF = 52;
endpackage

// File: rtl/card_rr_arbiter.sv
// card_rr_arbiter: two-requester round-robin; latches the grant id and moves the last-served pointer on completion.
module card_rr_arbiter
    import card_deal_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic player_req_i,
    input  logic dealer_req_i,
    input  logic done_i,
    output logic gnt_o,
    output logic gnt_id_o
);
    logic last_q, last_d, id_q, id_d;
    always_comb begin
        gnt_o  = en_i & (player_req_i | dealer_req_i);
        // on a tie the side not served last wins; otherwise the lone requester
        id_d   = gnt_o ? ((player_req_i & dealer_req_i) ? ~last_q : dealer_req_i) : id_q;
        last_d = done_i ? id_q : last_q;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= DEALER;
            id_q   <= PLAYER;
        end else begin
            last_q <= last_d;
            id_q   <= id_d;
        end
    end
    assign gnt_id_o = id_q;
endmodule

// File: rtl/card_deal_controller.sv
// card_deal_controller: arbitrates player/dealer card requests, pulses the datapath once per grant,
// waits DP_LAT cycles, returns the captured card with a one-cycle strobe and tracks cards dealt per shoe.
module card_deal_controller
    import card_deal_pkg::*;
#(
    parameter int CARD_W    = 8,
    parameter int DP_LAT    = 1,
    parameter int DECK_SIZE = DECK_SIZE_DEF,
    parameter int CNT_W     = 6
) (
    input  logic              clk_ct_i,
    input  logic              rst_ct_i,
    input  logic              player_req_ct_i,
    input  logic              dealer_req_ct_i,
    input  logic              reshuffle_ct_i,
    input  logic [CARD_W-1:0] card_dp_ct_i,
    output logic              req_card_state_ct_o,
    output logic [CARD_W-1:0] card_ct_o,
    output logic              player_valid_ct_o,
    output logic              dealer_valid_ct_o,
    output logic              busy_ct_o,
    output logic              deck_empty_ct_o,
    output logic [CNT_W-1:0]  cards_dealt_ct_o
);
    localparam int WAIT_W = $clog2(DP_LAT + 1);
    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [CARD_W-1:0]   card_q, card_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                empty_q, empty_d;
    logic                req_q, req_d;
    logic                pv_q, pv_d;
    logic                dv_q, dv_d;
    logic                busy_q, busy_d;
    logic                gnt, gnt_id;

    card_rr_arbiter u_arb (
        .clk_i        (clk_ct_i),
        .rst_i        (rst_ct_i),
        .en_i         (state_q == ST_IDLE && !empty_q),
        .player_req_i (player_req_ct_i),
        .dealer_req_i (dealer_req_ct_i),
        .done_i       (state_q == ST_DELIVER),
        .gnt_o        (gnt),
        .gnt_id_o     (gnt_id)
    );

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        card_d  = card_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE:    state_d = gnt ? ST_REQ : ST_IDLE;
            ST_REQ: begin
                state_d = ST_WAIT;
                wait_d  = WAIT_W'(DP_LAT);
            end
            ST_WAIT: begin
                if (wait_q == WAIT_W'(1)) begin
                    card_d  = card_dp_ct_i;
                    state_d = ST_DELIVER;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = (cnt_q == CNT_W'(DECK_SIZE)) ? cnt_q : cnt_q + CNT_W'(1);
            end
        endcase
        // a reshuffle overrides any increment landing on the same edge
        cnt_d   = reshuffle_ct_i ? '0 : cnt_d;
        empty_d = cnt_d == CNT_W'(DECK_SIZE);
        req_d   = state_d == ST_REQ;
        pv_d    = state_d == ST_DELIVER && gnt_id == PLAYER;
        dv_d    = state_d == ST_DELIVER && gnt_id == DEALER;
        busy_d  = state_d != ST_IDLE;
    end

    always_ff @(posedge clk_ct_i) begin
        if (rst_ct_i) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
            card_q  <= '0;
            cnt_q   <= '0;
            empty_q <= 1'b0;
            req_q   <= 1'b0;
            pv_q    <= 1'b0;
            dv_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            card_q  <= card_d;
            cnt_q   <= cnt_d;
            empty_q <= empty_d;
            req_q   <= req_d;
            pv_q    <= pv_d;
            dv_q    <= dv_d;
            busy_q  <= busy_d;
        end
    end

    assign req_card_state_ct_o = req_q;
    assign card_ct_o           = card_q;
    assign player_valid_ct_o   = pv_q;
    assign dealer_valid_ct_o   = dv_q;
    assign busy_ct_o           = busy_q;
    assign deck_empty_ct_o     = empty_q;
    assign cards_dealt_ct_o    = cnt_q;
endmodule

// File: tb/tb_card_deal_controller.sv
// tb_card_deal_controller: directed checks of grant order, latency, deck-empty, reshuffle and reset behaviour.
module tb_card_deal_controller;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       p_a = 1'b0, d_a = 1'b0, rs_a = 1'b0;
    logic [7:0] dp_a = 8'h00;
    logic       req_a, pv_a, dv_a, busy_a, empty_a;
    logic [7:0] card_a;
    logic [5:0] cnt_a;
    logic       p_b = 1'b0;
    logic [7:0] dp_b = 8'h00;
    logic       req_b, pv_b, dv_b, busy_b, empty_b;
    logic [7:0] card_b;
    logic [5:0] cnt_b;
    int n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    card_deal_controller #(.CARD_W(8), .DP_LAT(1), .DECK_SIZE(4), .CNT_W(6)) u_a (
        .clk_ct_i(clk), .rst_ct_i(rst), .player_req_ct_i(p_a), .dealer_req_ct_i(d_a),
        .reshuffle_ct_i(rs_a), .card_dp_ct_i(dp_a), .req_card_state_ct_o(req_a),
        .card_ct_o(card_a), .player_valid_ct_o(pv_a), .dealer_valid_ct_o(dv_a),
        .busy_ct_o(busy_a), .deck_empty_ct_o(empty_a), .cards_dealt_ct_o(cnt_a)
    );

    card_deal_controller #(.CARD_W(8), .DP_LAT(3), .DECK_SIZE(52), .CNT_W(6)) u_b (
        .clk_ct_i(clk), .rst_ct_i(rst), .player_req_ct_i(p_b), .dealer_req_ct_i(1'b0),
        .reshuffle_ct_i(1'b0), .card_dp_ct_i(dp_b), .req_card_state_ct_o(req_b),
        .card_ct_o(card_b), .player_valid_ct_o(pv_b), .dealer_valid_ct_o(dv_b),
        .busy_ct_o(busy_b), .deck_empty_ct_o(empty_b), .cards_dealt_ct_o(cnt_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // the second datapath model produces a new card every cycle
    task automatic tick();
        @(posedge clk);
        #1;
        dp_b = dp_b + 8'h11;
    endtask

    task automatic wait_pv(input string tag, input int budget);
        bit hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            tick();
            hit = pv_a;
        end
        check(tag, hit, 1);
    endtask

    initial begin
        logic [7:0] exp_card;
        logic       order[$];
        int pulses, both;
        // reset values
        tick(); tick();
        check("rst_req", req_a, 0);
        check("rst_pv", pv_a, 0);
        check("rst_dv", dv_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_empty", empty_a, 0);
        check("rst_card", card_a, 0);
        check("rst_cnt", cnt_a, 0);
        // player only, DP_LAT=1
        rst = 0; p_a = 1; dp_a = 8'h15;
        check("p_c0_req", req_a, 0);
        tick();
        check("p_c1_req", req_a, 1);
        check("p_c1_busy", busy_a, 1);
        tick();
        check("p_c2_req", req_a, 0);
        check("p_c2_pv", pv_a, 0);
        tick();
        check("p_c3_pv", pv_a, 1);
        check("p_c3_dv", dv_a, 0);
        check("p_c3_card", card_a, 8'h15);
        p_a = 0;
        tick();
        check("p_c4_pv", pv_a, 0);
        check("p_c4_cnt", cnt_a, 1);
        check("p_c4_busy", busy_a, 0);
        // DP_LAT=3 with a changing datapath
        rst = 1; tick(); tick();
        rst = 0; p_b = 1;
        tick();
        check("l3_c1_req", req_b, 1);
        tick();
        check("l3_c2_req", req_b, 0);
        tick(); tick();
        exp_card = dp_b;
        check("l3_c4_pv", pv_b, 0);
        tick();
        check("l3_c5_pv", pv_b, 1);
        check("l3_c5_card", card_b, exp_card);
        p_b = 0;
        tick();
        check("l3_cnt", cnt_b, 1);
        // both held from reset: round-robin order, then deck empty
        rst = 1; tick(); tick();
        rst = 0; p_a = 1; d_a = 1; dp_a = 8'h27;
        pulses = 0; both = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (req_a) pulses++;
            if (pv_a && dv_a) both++;
            if (pv_a) order.push_back(1'b0);
            if (dv_a) order.push_back(1'b1);
        end
        check("rr_pulses", pulses, 4);
        check("rr_both", both, 0);
        check("rr_n", order.size(), 4);
        check("rr_0", order[0], 0);
        check("rr_1", order[1], 1);
        check("rr_2", order[2], 0);
        check("rr_3", order[3], 1);
        check("rr_cnt", cnt_a, 4);
        check("rr_empty", empty_a, 1);
        check("rr_busy", busy_a, 0);
        // reshuffle releases the pending requests
        rs_a = 1;
        tick();
        rs_a = 0;
        check("rs_cnt", cnt_a, 0);
        check("rs_empty", empty_a, 0);
        tick();
        check("rs_req", req_a, 1);
        tick();
        // reset during WAIT aborts the transaction
        rst = 1; dp_a = 8'hA5;
        tick();
        check("rw_pv", pv_a, 0);
        check("rw_req", req_a, 0);
        check("rw_busy", busy_a, 0);
        check("rw_card", card_a, 0);
        check("rw_cnt", cnt_a, 0);
        rst = 0; d_a = 0; dp_a = 8'h3C;
        wait_pv("rw_after_hit", 8);
        check("rw_after_card", card_a, 8'h3C);
        check("rw_after_dv", dv_a, 0);
        tick();
        check("rw_after_cnt", cnt_a, 1);
        // reshuffle coinciding with the fourth delivery
        rst = 1; tick();
        rst = 0; dp_a = 8'h42;
        wait_pv("co_hit1", 8);
        wait_pv("co_hit2", 8);
        wait_pv("co_hit3", 8);
        wait_pv("co_hit4", 8);
        check("co_cnt_pre", cnt_a, 3);
        rs_a = 1;
        tick();
        rs_a = 0; p_a = 0;
        check("co_cnt", cnt_a, 0);
        check("co_empty", empty_a, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
